axi_ral_reg_slave: RTL and testbench

//  AXI3 slave register block: the target behind slave port 0 (the _s1 signal set) of the pass-through

---
 rtl/axi_ral_reg_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_ral_reg_slave.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ral_reg_slave.sv
// rtl/axi_ral_reg_slave.sv - AXI3 slave register block with independent write and read FSMs
module axi_ral_reg_slave #(
    parameter int                ADDR_W    = 32,
    parameter int                ID_W      = 4,
    parameter int                NUM_REGS  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       ID_VALUE  = 32'hA11C_0001
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic [ID_W-1:0]   awid,
    input  logic              wvalid,
    output logic              wready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic [ID_W-1:0]   wid,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic [ID_W-1:0]   bid,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic [ID_W-1:0]   arid,
    output logic              rvalid,
    input  logic              rready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic [ID_W-1:0]   rid
);
    localparam int              IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0] LO    = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] HI    = LO + (ADDR_W+1)'(NUM_REGS * 4);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    // Addresses carry an extra MSB so INCR overflow lands out of range instead of wrapping
    function automatic logic in_range(input logic [ADDR_W:0] a);
        return (a >= LO) && (a < HI);
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_W:0] a);
        return IDX_W'((a - LO) >> 2);
    endfunction

    function automatic logic bad_cmd(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [1:0] lsb);
        return (size != 3'b010) || burst[1] || (lsb != 2'b00);
    endfunction

    logic [31:0] regs [NUM_REGS];

    w_state_t        w_state;
    logic [ADDR_W:0] wr_addr;
    logic [3:0]      wr_len;
    logic [4:0]      wr_beat;
    logic            wr_incr;
    logic            wr_err;
    logic            w_beat_err;
    logic [IDX_W-1:0] w_idx;

    r_state_t        r_state;
    logic [ADDR_W:0] rd_addr;
    logic [3:0]      rd_len;
    logic [3:0]      rd_beat;
    logic            rd_incr;
    logic            rd_err;
    logic [ADDR_W:0] ld_addr;
    logic            ld_err;
    logic [IDX_W-1:0] ld_idx;
    logic [31:0]     ld_data;

    logic unused_ok;
    assign unused_ok = ^{awlock, awcache, awprot, wid, arlock, arcache, arprot};

    always_comb begin
        w_idx      = reg_idx(wr_addr);
        w_beat_err = !in_range(wr_addr) || (wr_beat > {1'b0, wr_len})
                   || (wlast != (wr_beat == {1'b0, wr_len}));
    end

    // The beat about to be loaded onto R: beat 0 straight from AR, later beats from the next address
    always_comb begin
        if (r_state == R_IDLE) begin
            ld_addr = {1'b0, araddr};
            ld_err  = bad_cmd(arsize, arburst, araddr[1:0]);
        end else begin
            ld_addr = rd_incr ? rd_addr + (ADDR_W+1)'(4) : rd_addr;
            ld_err  = rd_err;
        end
        ld_err  = ld_err || !in_range(ld_addr);
        ld_idx  = reg_idx(ld_addr);
        ld_data = ld_err ? 32'h0 : ((ld_idx == '0) ? ID_VALUE : regs[ld_idx]);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            bid     <= '0;
            wr_addr <= '0;
            wr_len  <= '0;
            wr_beat <= '0;
            wr_incr <= 1'b0;
            wr_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (!awready) begin
                        awready <= 1'b1;
                    end else if (awvalid) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        wr_addr <= {1'b0, awaddr};
                        wr_len  <= awlen;
                        wr_beat <= '0;
                        wr_incr <= (awburst == 2'b01);
                        wr_err  <= bad_cmd(awsize, awburst, awaddr[1:0]);
                        bid     <= awid;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        // Once any beat errs, the rest of the burst is discarded
                        if (!wr_err && !w_beat_err && (w_idx != '0)) begin
                            for (int b = 0; b < 4; b++)
                                if (wstrb[b]) regs[w_idx][8*b +: 8] <= wdata[8*b +: 8];
                        end
                        wr_err <= wr_err || w_beat_err;
                        if (wr_beat != 5'h1f) wr_beat <= wr_beat + 5'd1;
                        if (wr_incr) wr_addr <= wr_addr + (ADDR_W+1)'(4);
                        if (wlast) begin
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (wr_err || w_beat_err) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 2'b00;
            rlast   <= 1'b0;
            rid     <= '0;
            rd_addr <= '0;
            rd_len  <= '0;
            rd_beat <= '0;
            rd_incr <= 1'b0;
            rd_err  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (!arready) begin
                        arready <= 1'b1;
                    end else if (arvalid) begin
                        arready <= 1'b0;
                        rd_addr <= ld_addr;
                        rd_len  <= arlen;
                        rd_beat <= '0;
                        rd_incr <= (arburst == 2'b01);
                        rd_err  <= bad_cmd(arsize, arburst, araddr[1:0]);
                        rid     <= arid;
                        rvalid  <= 1'b1;
                        rdata   <= ld_data;
                        rresp   <= ld_err ? 2'b10 : 2'b00;
                        rlast   <= (arlen == 4'd0);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rd_addr <= ld_addr;
                            rd_beat <= rd_beat + 4'd1;
                            rdata   <= ld_data;
                            rresp   <= ld_err ? 2'b10 : 2'b00;
                            rlast   <= ((rd_beat + 4'd1) == rd_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_ral_reg_slave.sv
// tb/tb_axi_ral_reg_slave.sv - scoreboard bench for axi_ral_reg_slave
module tb_axi_ral_reg_slave;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awlen, awcache;
    logic [2:0]  awsize, awprot;
    logic [1:0]  awburst, awlock;
    logic [3:0]  awid;
    logic        wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb, wid;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arlen, arcache;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arid;
    logic        rvalid, rready, rlast;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;

    axi_ral_reg_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awid(awid),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wid(wid),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;
    b_exp_t bq[$];
    r_exp_t rq[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push_b(input logic [1:0] resp, input logic [3:0] id);
        b_exp_t e;
        e.resp = resp; e.id = id;
        bq.push_back(e);
    endtask

    task automatic push_r(input logic [31:0] d, input logic [1:0] resp, input logic last,
                          input logic [3:0] id);
        r_exp_t e;
        e.data = d; e.resp = resp; e.last = last; e.id = id;
        rq.push_back(e);
    endtask

    // Monitor: pop and compare on every completed B/R handshake
    initial begin
        b_exp_t be;
        r_exp_t re;
        forever begin
            @(negedge aclk);
            if (aresetn && bvalid && bready) begin
                if (bq.size() == 0) tmo("b_unexpected");
                else begin
                    be = bq.pop_front();
                    chk("bresp", 32'(bresp), 32'(be.resp));
                    chk("bid", 32'(bid), 32'(be.id));
                end
            end
            if (aresetn && rvalid && rready) begin
                if (rq.size() == 0) tmo("r_unexpected");
                else begin
                    re = rq.pop_front();
                    chk("rdata", rdata, re.data);
                    chk("rresp", 32'(rresp), 32'(re.resp));
                    chk("rlast", 32'(rlast), 32'(re.last));
                    chk("rid", 32'(rid), 32'(re.id));
                end
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int t = 0;
        awvalid = 1'b1; awaddr = a; awlen = len; awsize = size; awburst = burst; awid = id;
        @(negedge aclk);
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        if (t >= 50) tmo("aw_handshake");
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_w(input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int t = 0;
            wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == nbeats - 1);
            @(negedge aclk);
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            if (t >= 50) tmo("w_handshake");
            @(posedge aclk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] len, input logic [1:0] burst,
                           input logic [3:0] id);
        int t = 0;
        arvalid = 1'b1; araddr = a; arlen = len; arsize = 3'b010; arburst = burst; arid = id;
        @(negedge aclk);
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        if (t >= 50) tmo("ar_handshake");
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_empty();
        int t = 0;
        while ((bq.size() != 0 || rq.size() != 0) && t < 200) begin @(negedge aclk); t++; end
        if (t >= 200) begin tmo("response_drain"); bq.delete(); rq.delete(); end
        @(posedge aclk); #1;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [3:0] id, input logic [1:0] resp);
        push_b(resp, id);
        send_aw(a, 4'd0, 3'b010, 2'b01, id);
        wd[0] = d; ws[0] = s;
        send_w(1);
        wait_empty();
    endtask

    task automatic rd1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] id);
        push_r(d, 2'b00, 1'b1, id);
        send_ar(a, 4'd0, 2'b01, id);
        wait_empty();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int t;
        aresetn = 1'b0;
        awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awlock = 0; awcache = 0;
        awprot = 0; awid = 0; wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; wid = 0;
        bready = 1; arvalid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arlock = 0;
        arcache = 0; arprot = 0; arid = 0; rready = 1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_awready", 32'(awready), 0);
        chk("rst_arready", 32'(arready), 0);
        chk("rst_bvalid", 32'(bvalid), 0);
        chk("rst_rvalid", 32'(rvalid), 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_awready_low", 32'(awready), 0);
        @(negedge aclk);
        chk("rel_awready_high", 32'(awready), 1);
        chk("rel_arready_high", 32'(arready), 1);
        @(posedge aclk); #1;

        // 1: single write/read
        wr1(32'h4, 32'hDEADBEEF, 4'hF, 4'h1, 2'b00);
        rd1(32'h4, 32'hDEADBEEF, 4'h2);

        // 2: INCR burst with partial strobe on beat 1
        wr1(32'hC, 32'hAAAA5555, 4'hF, 4'h3, 2'b00);
        push_b(2'b00, 4'h4);
        send_aw(32'h8, 4'd3, 3'b010, 2'b01, 4'h4);
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        ws[0] = 4'hF; ws[1] = 4'h3; ws[2] = 4'hF; ws[3] = 4'hF;
        send_w(4);
        wait_empty();
        push_r(32'h11111111, 2'b00, 1'b0, 4'h5);
        push_r(32'hAAAA2222, 2'b00, 1'b0, 4'h5);
        push_r(32'h33333333, 2'b00, 1'b0, 4'h5);
        push_r(32'h44444444, 2'b00, 1'b1, 4'h5);
        send_ar(32'h8, 4'd3, 2'b01, 4'h5);
        wait_empty();

        // 3: ID register is read-only
        rd1(32'h0, 32'hA11C0001, 4'h6);
        wr1(32'h0, 32'h0, 4'hF, 4'h7, 2'b00);
        rd1(32'h0, 32'hA11C0001, 4'h8);

        // 4: read burst running off the end of the block
        push_b(2'b00, 4'h9);
        send_aw(32'h38, 4'd1, 3'b010, 2'b01, 4'h9);
        wd[0] = 32'h0E0E0E0E; wd[1] = 32'hF0F0F0F0; ws[0] = 4'hF; ws[1] = 4'hF;
        send_w(2);
        wait_empty();
        push_r(32'h0E0E0E0E, 2'b00, 1'b0, 4'hA);
        push_r(32'hF0F0F0F0, 2'b00, 1'b0, 4'hA);
        push_r(32'h0, 2'b10, 1'b0, 4'hA);
        push_r(32'h0, 2'b10, 1'b1, 4'hA);
        send_ar(32'h38, 4'd3, 2'b01, 4'hA);
        wait_empty();

        // FIXED bursts hit the same register every beat
        push_b(2'b00, 4'hB);
        send_aw(32'h18, 4'd2, 3'b010, 2'b00, 4'hB);
        wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3; ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        send_w(3);
        wait_empty();
        push_r(32'h3, 2'b00, 1'b0, 4'hC);
        push_r(32'h3, 2'b00, 1'b1, 4'hC);
        send_ar(32'h18, 4'd1, 2'b00, 4'hC);
        wait_empty();

        // 5: error writes leave registers untouched
        push_b(2'b10, 4'h1);
        send_aw(32'h10, 4'd0, 3'b001, 2'b01, 4'h1);
        wd[0] = 32'h12345678; ws[0] = 4'hF;
        send_w(1);
        wait_empty();
        push_b(2'b10, 4'h2);
        send_aw(32'h10, 4'd1, 3'b010, 2'b10, 4'h2);
        wd[0] = 32'hBAD0BAD0; wd[1] = 32'hBAD0BAD0; ws[0] = 4'hF; ws[1] = 4'hF;
        send_w(2);
        wait_empty();
        rd1(32'h10, 32'h33333333, 4'h3);
        push_b(2'b10, 4'h4);
        send_aw(32'h20, 4'd3, 3'b010, 2'b01, 4'h4);
        wd[0] = 32'h55555555; wd[1] = 32'h66666666; ws[0] = 4'hF; ws[1] = 4'hF;
        send_w(2);
        wait_empty();
        rd1(32'h24, 32'h0, 4'h5);
        wr1(32'h6, 32'h77777777, 4'hF, 4'h6, 2'b10);
        rd1(32'h4, 32'hDEADBEEF, 4'h7);
        wr1(32'h40, 32'h77777777, 4'hF, 4'h8, 2'b10);

        // 6a: B held while bready is low
        bready = 1'b0;
        push_b(2'b00, 4'h9);
        send_aw(32'h28, 4'd0, 3'b010, 2'b01, 4'h9);
        wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
        send_w(1);
        t = 0;
        while (!bvalid && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) tmo("b_stall_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("b_stall_valid", 32'(bvalid), 1);
            chk("b_stall_id", 32'(bid), 32'h9);
        end
        @(posedge aclk); #1;
        bready = 1'b1;
        wait_empty();

        // 6b: R held while rready is low
        rready = 1'b0;
        push_r(32'hCAFEF00D, 2'b00, 1'b0, 4'hD);
        push_r(32'h0, 2'b00, 1'b1, 4'hD);
        send_ar(32'h28, 4'd1, 2'b01, 4'hD);
        t = 0;
        while (!rvalid && t < 20) begin @(negedge aclk); t++; end
        if (t >= 20) tmo("r_stall_wait");
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("r_stall_data", rdata, 32'hCAFEF00D);
            chk("r_stall_last", 32'(rlast), 0);
        end
        @(posedge aclk); #1;
        rready = 1'b1;
        wait_empty();

        // 6c: reset in the middle of a write burst
        send_aw(32'h20, 4'd3, 3'b010, 2'b01, 4'h5);
        wd[0] = 32'h5A5A5A5A; ws[0] = 4'hF;
        wvalid = 1'b1; wdata = wd[0]; wstrb = ws[0]; wlast = 1'b0;
        @(posedge aclk); #1;
        wvalid = 1'b0;
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid_awready", 32'(awready), 0);
        chk("mid_wready", 32'(wready), 0);
        chk("mid_bvalid", 32'(bvalid), 0);
        chk("mid_bresp", 32'(bresp), 0);
        chk("mid_bid", 32'(bid), 0);
        chk("mid_arready", 32'(arready), 0);
        chk("mid_rvalid", 32'(rvalid), 0);
        chk("mid_rdata", rdata, 0);
        chk("mid_rlast", 32'(rlast), 0);
        chk("mid_rid", 32'(rid), 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        push_r(32'hA11C0001, 2'b00, 1'b0, 4'hE);
        push_r(32'h0, 2'b00, 1'b1, 4'hE);
        send_ar(32'h0, 4'd1, 2'b01, 4'hE);
        wait_empty();
        rd1(32'h10, 32'h0, 4'hF);
        rd1(32'h20, 32'h0, 4'h1);

        repeat (5) @(posedge aclk);
        if (bq.size() != 0 || rq.size() != 0) tmo("leftover_expected");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
